axi3_slave_memory: RTL and testbench

//  AXI3 32-bit slave backed by a word-addressed on-chip memory. Sits directly downstream of the
//  HP-port AXI master/stimulator (and later DMA masters), standing in for the PS HP port in sim and

---
 rtl/axi3_slave_memory.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_axi3_slave_memory.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_slave_memory.sv
// axi3_slave_memory
//   AXI3 32-bit slave backed by a word-addressed on-chip memory. One
//   transaction in flight, INCR/FIXED bursts, byte strobes, SLVERR on illegal
//   beats and a saturating count of error responses for GPIO readout.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   ar* / aw* / w*       AXI3 read-address, write-address, write-data channels
//                        (lock/cache/prot/qos accepted and ignored)
//   b* / r*              AXI3 write-response and read-data channels
//   error_count          saturating count of SLVERR bursts (write or read)
module axi3_slave_memory #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ID_WIDTH  = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                arvalid,
    output logic                arready,
    input  logic [31:0]         araddr,
    input  logic [3:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [1:0]          arlock,
    input  logic [3:0]          arcache,
    input  logic [2:0]          arprot,
    input  logic [3:0]          arqos,
    input  logic                awvalid,
    output logic                awready,
    input  logic [31:0]         awaddr,
    input  logic [3:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [1:0]          awlock,
    input  logic [3:0]          awcache,
    input  logic [2:0]          awprot,
    input  logic [3:0]          awqos,
    input  logic                wvalid,
    output logic                wready,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                wlast,
    input  logic [ID_WIDTH-1:0] wid,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    output logic [ID_WIDTH-1:0] bid,
    output logic                rvalid,
    input  logic                rready,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic [ID_WIDTH-1:0] rid,
    output logic                rlast,
    output logic [7:0]          error_count
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(DEPTH) * 33'd4;

    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RFETCH, S_RDATA} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [3:0]          len_q, len_d, beat_q, beat_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                err_q, err_d;
    logic                wb_valid_q, wb_valid_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic [3:0]          wb_strb_q, wb_strb_d;
    logic                wb_last_q, wb_last_d;
    logic [ID_WIDTH-1:0] wb_id_q, wb_id_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [31:0]         mem_q [DEPTH];

    logic [31:0]         sel_addr;
    logic [3:0]          sel_len, sel_beat;
    logic [2:0]          sel_size;
    logic [1:0]          sel_burst;
    logic [ID_WIDTH-1:0] sel_id;
    logic [32:0]         cur_addr;
    logic [AW-1:0]       word;
    logic                req_err, is_last;
    logic [31:0]         w_data;
    logic [3:0]          w_strb;
    logic                w_last;
    logic [ID_WIDTH-1:0] w_id;
    logic                wbeat_err, mem_we;

    logic unused_sideband;
    assign unused_sideband = ^{arlock, arcache, arprot, arqos, awlock, awcache, awprot, awqos};

    // Beat view: in IDLE a write beat can be consumed in the AW handshake
    // cycle, so the live AW fields stand in for the not-yet-latched ones.
    always_comb begin
        sel_addr  = addr_q;
        sel_len   = len_q;
        sel_size  = size_q;
        sel_burst = burst_q;
        sel_id    = id_q;
        sel_beat  = beat_q;
        if (state_q == S_IDLE) begin
            sel_addr  = awaddr;
            sel_len   = awlen;
            sel_size  = awsize;
            sel_burst = awburst;
            sel_id    = awid;
            sel_beat  = '0;
        end
        cur_addr = (sel_burst == 2'b01) ? {1'b0, sel_addr} + {27'b0, sel_beat, 2'b00}
                                        : {1'b0, sel_addr};
        // BASE_ADDR is DEPTH*4-aligned, so the low address bits are the word index.
        word     = cur_addr[AW+1:2];
        req_err  = sel_burst[1] || (sel_size != 3'b010) ||
                   (cur_addr < LO_ADDR) || (cur_addr >= HI_ADDR);
        is_last  = (sel_beat == sel_len);

        if (state_q == S_IDLE && wb_valid_q) begin
            w_data = wb_data_q;
            w_strb = wb_strb_q;
            w_last = wb_last_q;
            w_id   = wb_id_q;
        end else begin
            w_data = wdata;
            w_strb = wstrb;
            w_last = wlast;
            w_id   = wid;
        end
        wbeat_err = req_err || (w_id != sel_id) || (w_last != is_last);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        id_d       = id_q;
        beat_d     = beat_q;
        err_d      = err_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_strb_d  = wb_strb_q;
        wb_last_d  = wb_last_q;
        wb_id_d    = wb_id_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        cnt_d      = cnt_q;
        awready    = 1'b0;
        arready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bresp      = 2'b00;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                awready = 1'b1;
                wready  = !wb_valid_q;
                arready = !awvalid;
                if (awvalid) begin
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    id_d    = awid;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_WDATA;
                    if (wb_valid_q || wvalid) begin
                        wb_valid_d = 1'b0;
                        mem_we     = !wbeat_err;
                        err_d      = wbeat_err;
                        if (is_last) state_d = S_WRESP;
                        else         beat_d  = 4'd1;
                    end
                end else begin
                    if (arvalid) begin
                        addr_d  = araddr;
                        len_d   = arlen;
                        size_d  = arsize;
                        burst_d = arburst;
                        id_d    = arid;
                        beat_d  = '0;
                        err_d   = 1'b0;
                        state_d = S_RFETCH;
                    end
                    if (wvalid && !wb_valid_q) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = wdata;
                        wb_strb_d  = wstrb;
                        wb_last_d  = wlast;
                        wb_id_d    = wid;
                    end
                end
            end
            S_WDATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = !wbeat_err;
                    err_d  = err_q | wbeat_err;
                    if (is_last) state_d = S_WRESP;
                    else         beat_d  = beat_q + 4'd1;
                end
            end
            S_WRESP: begin
                bvalid = 1'b1;
                bresp  = err_q ? 2'b10 : 2'b00;
                if (bready) begin
                    state_d = S_IDLE;
                    if (err_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
            S_RFETCH: begin
                rdata_d = req_err ? '0 : mem_q[word];
                rresp_d = req_err ? 2'b10 : 2'b00;
                err_d   = err_q | req_err;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                rvalid = 1'b1;
                rlast  = is_last;
                if (rready) begin
                    if (is_last) begin
                        state_d = S_IDLE;
                        if (err_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        state_d = S_RFETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_strb_q  <= '0;
            wb_last_q  <= 1'b0;
            wb_id_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            id_q       <= id_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_strb_q  <= wb_strb_d;
            wb_last_q  <= wb_last_d;
            wb_id_q    <= wb_id_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            cnt_q      <= cnt_d;
        end
    end

    // Memory contents survive reset; writes are blocked while reset is held.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_strb[i]) mem_q[word][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    assign bid         = id_q;
    assign rid         = id_q;
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign error_count = cnt_q;

endmodule

// File: tb/tb_axi3_slave_memory.sv
module tb_axi3_slave_memory;

    localparam int unsigned DEPTH = 128;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int unsigned IDW   = 6;
    localparam longint      LO    = 64'h4000_0000;
    localparam longint      HI    = LO + DEPTH * 4;

    logic clock, reset;
    logic arvalid, arready, awvalid, awready, wvalid, wready, wlast;
    logic bvalid, bready, rvalid, rready, rlast;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, bresp, rresp;
    logic [IDW-1:0] arid, awid, wid, bid, rid;
    logic [7:0]  error_count;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_exp = 0;
    int bad_wid_beat = -1;
    int bad_last_beat = -1;
    logic [31:0] mdl [DEPTH];
    logic [31:0] tx_data [16];
    logic [3:0]  tx_strb [16];

    axi3_slave_memory #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ID_WIDTH(IDW)) dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .arlock(2'b00), .arcache(4'h0), .arprot(3'b000), .arqos(4'h0),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .awlock(2'b00), .awcache(4'h0), .awprot(3'b000), .awqos(4'h0),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rid(rid), .rlast(rlast), .error_count(error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic longint beat_addr(input logic [31:0] a, input logic [1:0] b, input int i);
        longint base_a = longint'({32'h0, a});
        return (b == 2'b01) ? base_a + 4 * i : base_a;
    endfunction

    function automatic bit beat_bad(input longint a, input logic [1:0] b, input logic [2:0] s);
        return (b > 2'b01) || (s != 3'd2) || (a < LO) || (a >= HI);
    endfunction

    function automatic int word_of(input longint a);
        return int'((a - LO) / 4);
    endfunction

    task automatic bump();
        if (cnt_exp < 255) cnt_exp++;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [IDW-1:0] id);
        bit err = 0;
        longint a;
        int w;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, i);
            if (beat_bad(a, burst, size) || i == bad_wid_beat || i == bad_last_beat) err = 1;
            else begin
                w = word_of(a);
                for (int b = 0; b < 4; b++)
                    if (tx_strb[i][b]) mdl[w][8*b +: 8] = tx_data[i][8*b +: 8];
            end
        end
        if (err) bump();
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clock);
            awvalid = (i == 0);
            if (i == 0) begin
                awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id;
            end
            wvalid = 1'b1;
            wdata  = tx_data[i];
            wstrb  = tx_strb[i];
            wlast  = (i == int'(len)) ^ (i == bad_last_beat);
            wid    = (i == bad_wid_beat) ? {id[IDW-1:1], ~id[0]} : id;
            #1;
            chk("wready_beat", wready, 1);
            if (i == 0) begin
                chk("awready", awready, 1);
                chk("arready_during_aw", arready, 0);
            end
        end
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        chk("bvalid_latency", bvalid, 1);
        chk("bresp", bresp, err ? 2'b10 : 2'b00);
        chk("bid", bid, id);
        @(negedge clock);
        bready = 1'b0;
        #1;
        chk("bvalid_drop", bvalid, 0);
        chk("error_count_w", error_count, cnt_exp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [IDW-1:0] id,
                           input int stall_beat, input int stall_len);
        bit any_err = 0;
        longint a;
        logic [31:0] ed;
        logic [1:0] er;
        @(negedge clock);
        arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id;
        #1;
        chk("arready", arready, 1);
        @(negedge clock);
        arvalid = 1'b0;
        #1;
        chk("rvalid_fetch", rvalid, 0);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, i);
            if (beat_bad(a, burst, size)) begin
                ed = 32'h0; er = 2'b10; any_err = 1;
            end else begin
                ed = mdl[word_of(a)]; er = 2'b00;
            end
            @(negedge clock);
            #1;
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, ed);
            chk("rresp", rresp, er);
            chk("rlast", rlast, (i == int'(len)));
            chk("rid", rid, id);
            if (i == stall_beat) begin
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clock);
                    #1;
                    chk("rvalid_hold", rvalid, 1);
                    chk("rdata_hold", rdata, ed);
                    chk("rresp_hold", rresp, er);
                end
            end
            rready = 1'b1;
            @(negedge clock);
            rready = 1'b0;
            #1;
            chk("rvalid_after_hs", rvalid, 0);
        end
        if (any_err) bump();
        chk("error_count_r", error_count, cnt_exp);
    endtask

    int off;
    logic [31:0] ra;
    logic [3:0]  rl;
    logic [1:0]  rb;
    logic [2:0]  rs;
    logic [31:0] tmp;

    initial begin
        reset = 1'b0;
        arvalid = 0; awvalid = 0; wvalid = 0; bready = 0; rready = 0; wlast = 0;
        araddr = '0; awaddr = '0; wdata = '0; arlen = '0; awlen = '0; wstrb = '0;
        arsize = '0; awsize = '0; arburst = '0; awburst = '0; arid = '0; awid = '0; wid = '0;
        #1;
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_error_count", error_count, 0);
        chk("rst_awready", awready, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // fill the whole memory with INCR bursts
        for (int k = 0; k < int'(DEPTH / 16); k++) begin
            for (int i = 0; i < 16; i++) begin tx_data[i] = $urandom; tx_strb[i] = 4'hF; end
            do_write(BASE + 32'(k * 64), 4'd15, 2'b01, 3'd2, IDW'(k));
        end

        // single write + read
        tx_data[0] = 32'hAABB_CC00; tx_strb[0] = 4'hF;
        do_write(BASE + 32'h100, 4'd0, 2'b01, 3'd2, 6'd5);
        do_read(BASE + 32'h100, 4'd0, 2'b01, 3'd2, 6'd11, -1, 0);

        // strobes + INCR burst, rready stall
        for (int i = 0; i < 4; i++) begin tx_data[i] = 32'(i + 1); tx_strb[i] = 4'hF; end
        do_write(BASE, 4'd3, 2'b01, 3'd2, 6'd1);
        tx_data[0] = 32'hFF; tx_strb[0] = 4'b0001;
        do_write(BASE + 32'h4, 4'd0, 2'b01, 3'd2, 6'd2);
        do_read(BASE, 4'd3, 2'b01, 3'd2, 6'd3, 1, 3);

        // FIXED burst: last beat wins
        for (int i = 0; i < 4; i++) begin tx_data[i] = 32'hC0DE_0000 + 32'(i); tx_strb[i] = 4'hF; end
        do_write(BASE + 32'h20, 4'd3, 2'b00, 3'd2, 6'd4);
        do_read(BASE + 32'h20, 4'd2, 2'b00, 3'd2, 6'd4, -1, 0);

        // error cases
        tx_data[0] = 32'hDEAD_BEEF; tx_strb[0] = 4'hF;
        do_write(BASE + DEPTH * 4, 4'd0, 2'b01, 3'd2, 6'd7);
        do_read(BASE, 4'd0, 2'b01, 3'd2, 6'd7, -1, 0);
        do_read(BASE + DEPTH * 4, 4'd0, 2'b01, 3'd2, 6'd7, -1, 0);
        do_read(BASE - 32'd4, 4'd0, 2'b01, 3'd2, 6'd7, -1, 0);
        for (int i = 0; i < 4; i++) begin tx_data[i] = $urandom; tx_strb[i] = 4'hF; end
        do_write(BASE + 32'h10, 4'd3, 2'b10, 3'd2, 6'd8);
        do_read(BASE + 32'h10, 4'd3, 2'b10, 3'd2, 6'd8, -1, 0);
        do_read(BASE + 32'h10, 4'd3, 2'b01, 3'd2, 6'd8, -1, 0);
        do_write(BASE + DEPTH * 4 - 32'd4, 4'd3, 2'b01, 3'd2, 6'd9);
        do_read(BASE + DEPTH * 4 - 32'd4, 4'd3, 2'b01, 3'd2, 6'd9, -1, 0);
        do_read(BASE + 32'h30, 4'd0, 2'b01, 3'd1, 6'd9, -1, 0);
        for (int i = 0; i < 3; i++) begin tx_data[i] = $urandom; tx_strb[i] = 4'hF; end
        bad_wid_beat = 1;
        do_write(BASE + 32'h40, 4'd2, 2'b01, 3'd2, 6'd12);
        bad_wid_beat = -1;
        bad_last_beat = 0;
        do_write(BASE + 32'h60, 4'd2, 2'b01, 3'd2, 6'd13);
        bad_last_beat = -1;
        do_read(BASE + 32'h40, 4'd15, 2'b01, 3'd2, 6'd14, -1, 0);

        // W before AW: buffered, wready drops until the AW arrives
        tmp = $urandom;
        @(negedge clock);
        wvalid = 1; wdata = tmp; wstrb = 4'hF; wlast = 1; wid = 6'd9;
        #1;
        chk("wbuf_wready", wready, 1);
        @(negedge clock);
        wvalid = 0; wlast = 0;
        #1;
        chk("wbuf_full_wready", wready, 0);
        repeat (2) begin
            @(negedge clock);
            #1;
            chk("wbuf_wait_wready", wready, 0);
        end
        mdl[16] = tmp;
        @(negedge clock);
        awvalid = 1; awaddr = BASE + 32'h40; awlen = 0; awburst = 2'b01; awsize = 3'd2; awid = 6'd9;
        #1;
        chk("wbuf_awready", awready, 1);
        @(negedge clock);
        awvalid = 0; bready = 1;
        #1;
        chk("wbuf_bvalid", bvalid, 1);
        chk("wbuf_bresp", bresp, 2'b00);
        chk("wbuf_bid", bid, 6'd9);
        @(negedge clock);
        bready = 0;
        #1;
        chk("wbuf_empty_wready", wready, 1);
        do_read(BASE + 32'h40, 4'd0, 2'b01, 3'd2, 6'd15, -1, 0);

        // simultaneous AW + AR: write wins
        tmp = $urandom;
        @(negedge clock);
        awvalid = 1; awaddr = BASE + 32'h80; awlen = 0; awburst = 2'b01; awsize = 3'd2; awid = 6'd2;
        wvalid = 1; wdata = tmp; wstrb = 4'hF; wlast = 1; wid = 6'd2;
        arvalid = 1; araddr = BASE + 32'h80; arlen = 0; arburst = 2'b01; arsize = 3'd2; arid = 6'd4;
        #1;
        chk("race_arready", arready, 0);
        chk("race_awready", awready, 1);
        mdl[32] = tmp;
        @(negedge clock);
        awvalid = 0; wvalid = 0; wlast = 0; bready = 1;
        #1;
        chk("race_bvalid", bvalid, 1);
        chk("race_arready_wresp", arready, 0);
        @(negedge clock);
        bready = 0;
        #1;
        chk("race_arready_idle", arready, 1);
        @(negedge clock);
        arvalid = 0;
        #1;
        chk("race_rvalid_fetch", rvalid, 0);
        @(negedge clock);
        #1;
        chk("race_rvalid", rvalid, 1);
        chk("race_rdata", rdata, tmp);
        chk("race_rid", rid, 6'd4);
        rready = 1;
        @(negedge clock);
        rready = 0;

        // randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            off = int'($urandom_range(0, DEPTH + 3)) - 2;
            ra  = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            rl  = 4'($urandom_range(0, 15));
            rb  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            rs  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin tx_data[i] = $urandom; tx_strb[i] = 4'($urandom); end
                do_write(ra, rl, rb, rs, IDW'($urandom));
            end else begin
                do_read(ra, rl, rb, rs, IDW'($urandom), int'($urandom_range(0, rl)), int'($urandom_range(0, 3)));
            end
        end

        // error counter saturation
        tx_data[0] = 32'h0; tx_strb[0] = 4'hF;
        while (cnt_exp < 255) do_write(BASE + DEPTH * 4, 4'd0, 2'b01, 3'd2, 6'd1);
        repeat (3) do_write(BASE + DEPTH * 4, 4'd0, 2'b01, 3'd2, 6'd1);
        chk("error_count_sat", error_count, 8'd255);

        // reset in the middle of a read burst
        @(negedge clock);
        arvalid = 1; araddr = BASE; arlen = 4'd7; arburst = 2'b01; arsize = 3'd2; arid = 6'd3;
        #1;
        chk("mid_arready", arready, 1);
        @(negedge clock);
        arvalid = 0;
        @(negedge clock);
        #1;
        chk("mid_rvalid", rvalid, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rlast", rlast, 0);
        chk("mid_rst_awready", awready, 1);
        chk("mid_rst_arready", arready, 1);
        chk("mid_rst_wready", wready, 1);
        chk("mid_rst_error_count", error_count, 0);
        cnt_exp = 0;
        @(negedge clock);
        reset = 1'b1;
        do_read(BASE + 32'h100, 4'd0, 2'b01, 3'd2, 6'd5, -1, 0);
        do_read(BASE, 4'd3, 2'b01, 3'd2, 6'd6, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
